// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and default widths for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Owner of an access travelling through the arbiter / read pipeline
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 7;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Produces one-hot win
//               strobes for the current cycle and remembers the last winner
//               so that the other port takes the next conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic win_a,
    output logic win_b
);

    owner_t r_last_gnt;

    // Lone request wins outright; on a conflict the port not served last wins
    always_comb begin
        win_a = req_a & (~req_b | (r_last_gnt == OWN_B));
        win_b = req_b & (~req_a | (r_last_gnt == OWN_A));
    end

    // Priority pointer moves only when somebody is actually granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= OWN_B;
        end else if (win_a) begin
            r_last_gnt <= OWN_A;
        end else if (win_b) begin
            r_last_gnt <= OWN_B;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_2p
// Description : Shares one single-port synchronous RAM between requesters A
//               and B. Registers the winning command onto the RAM port,
//               pulses a per-port grant, and pulses a per-port read-valid
//               aligned with the RAM's registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic                  w_win_a;
    logic                  w_win_b;
    logic                  w_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_gnt_a;
    logic                  r_gnt_b;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    // Stage 1: read command sitting on the RAM port; stage 2: RAM has
    // sampled the address and ram_dout now carries the result.
    logic                  r_p1_vld;
    owner_t                r_p1_own;
    logic                  r_p2_vld;
    owner_t                r_p2_own;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .win_a (w_win_a),
        .win_b (w_win_b)
    );

    // Select the winning port's command fields
    always_comb begin
        w_grant     = w_win_a | w_win_b;
        w_sel_we    = w_win_b ? we_b    : we_a;
        w_sel_addr  = w_win_b ? addr_b  : addr_a;
        w_sel_wdata = w_win_b ? wdata_b : wdata_a;
    end

    // Command registers, grant pulses and the two-stage read tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_p1_vld   <= 1'b0;
            r_p1_own   <= OWN_A;
            r_p2_vld   <= 1'b0;
            r_p2_own   <= OWN_A;
        end else begin
            r_gnt_a  <= w_win_a;
            r_gnt_b  <= w_win_b;
            // Write enable drops on any cycle without a grant
            r_ram_we <= w_grant & w_sel_we;
            // Address and data hold while idle
            if (w_grant) begin
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_wdata;
            end
            r_p1_vld <= w_grant & ~w_sel_we;
            r_p1_own <= w_win_b ? OWN_B : OWN_A;
            r_p2_vld <= r_p1_vld;
            r_p2_own <= r_p1_own;
        end
    end

    // Drive outputs; read data comes straight from the RAM register
    always_comb begin
        gnt_a    = r_gnt_a;
        gnt_b    = r_gnt_b;
        rvalid_a = r_p2_vld & (r_p2_own == OWN_A);
        rvalid_b = r_p2_vld & (r_p2_own == OWN_B);
        ram_we   = r_ram_we;
        ram_addr = r_ram_addr;
        ram_din  = r_ram_din;
        rdata    = ram_dout;
    end

endmodule : ram_arbiter_2p
`default_nettype wire
